// File: rtl/eth_mac_tx_framer.sv
// GMII transmit framer: preamble/SFD, fixed Ethernet II header, payload, zero pad
// to 46 bytes, FCS taken from an external crc32_d8, and a forced inter-frame gap.
module eth_mac_tx_framer #(
    parameter logic [47:0] DST_MAC    = 48'hFF_FF_FF_FF_FF_FF,
    parameter logic [47:0] SRC_MAC    = 48'h00_0A_35_01_FE_C0,
    parameter logic [15:0] ETH_TYPE   = 16'h0800,
    parameter int          IFG_CYCLES = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  crc_data,
    output logic        crc_en,
    output logic        crc_init,
    input  logic [31:0] crc_result,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, HEADER, PAYLOAD, PAD, FCS, DRAIN, IFG} state_t;

    localparam logic [111:0] HDR      = {DST_MAC, SRC_MAC, ETH_TYPE};
    localparam logic [5:0]   MIN_PAY  = 6'd46;
    localparam logic [7:0]   IFG_LAST = 8'(IFG_CYCLES - 2);

    state_t     state, state_n;
    logic [7:0] cnt, cnt_n;
    logic [5:0] pay_cnt, pay_cnt_n, pay_inc;
    logic [7:0] txd_n;
    logic       tx_en_n, done_n, underrun_n, take;

    function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
        logic [111:0] sh;
        sh = HDR << {idx, 3'b000};
        return sh[111:104];
    endfunction

    function automatic logic [7:0] fcs_byte(input logic [31:0] c, input logic [1:0] idx);
        logic [31:0] sh;
        sh = c << {idx, 3'b000};
        return sh[31:24];
    endfunction

    // The state names what is on the wire; the logic below picks the byte for the next cycle.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        pay_cnt_n  = pay_cnt;
        pay_inc    = (pay_cnt == MIN_PAY) ? pay_cnt : pay_cnt + 6'd1;
        txd_n      = 8'h00;
        tx_en_n    = 1'b0;
        done_n     = 1'b0;
        underrun_n = 1'b0;
        crc_en     = 1'b0;
        crc_init   = 1'b0;
        s_ready    = 1'b0;
        take       = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid) begin
                    state_n   = PREAMBLE;
                    cnt_n     = 8'd0;
                    pay_cnt_n = 6'd0;
                    txd_n     = 8'h55;
                    tx_en_n   = 1'b1;
                end
            end
            PREAMBLE: begin
                tx_en_n = 1'b1;
                if (cnt == 8'd7) begin
                    txd_n   = hdr_byte(4'd0);
                    crc_en  = 1'b1;
                    state_n = HEADER;
                    cnt_n   = 8'd0;
                end else begin
                    crc_init = 1'b1;
                    txd_n    = (cnt == 8'd6) ? 8'hD5 : 8'h55;
                    cnt_n    = cnt + 8'd1;
                end
            end
            HEADER: begin
                if (cnt != 8'd13) begin
                    tx_en_n = 1'b1;
                    txd_n   = hdr_byte(cnt[3:0] + 4'd1);
                    crc_en  = 1'b1;
                    cnt_n   = cnt + 8'd1;
                end else begin
                    take = 1'b1;
                end
            end
            PAYLOAD: take = 1'b1;
            PAD: begin
                tx_en_n = 1'b1;
                if (pay_cnt < MIN_PAY) begin
                    crc_en    = 1'b1;
                    pay_cnt_n = pay_cnt + 6'd1;
                end else begin
                    // CRC is frozen from here on, so its result already covers every byte.
                    txd_n   = crc_result[31:24];
                    state_n = FCS;
                    cnt_n   = 8'd1;
                end
            end
            FCS: begin
                if (cnt < 8'd4) begin
                    tx_en_n = 1'b1;
                    txd_n   = fcs_byte(crc_result, cnt[1:0]);
                    cnt_n   = cnt + 8'd1;
                end else begin
                    done_n  = 1'b1;
                    state_n = IFG;
                    cnt_n   = 8'd0;
                end
            end
            DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_n = IFG;
                    cnt_n   = 8'd0;
                end
            end
            IFG: begin
                if (cnt >= IFG_LAST) state_n = IDLE;
                else                 cnt_n   = cnt + 8'd1;
            end
        endcase

        if (take) begin
            s_ready = 1'b1;
            if (s_valid) begin
                tx_en_n   = 1'b1;
                txd_n     = s_data;
                crc_en    = 1'b1;
                pay_cnt_n = pay_inc;
                cnt_n     = 8'd0;
                if (s_last) state_n = (pay_inc < MIN_PAY) ? PAD : FCS;
                else        state_n = PAYLOAD;
            end else begin
                underrun_n = 1'b1;
                state_n    = DRAIN;
            end
        end
    end

    assign crc_data = txd_n;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            pay_cnt    <= 6'd0;
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            pay_cnt    <= pay_cnt_n;
            gmii_txd   <= txd_n;
            gmii_tx_en <= tx_en_n;
            frame_done <= done_n;
            underrun   <= underrun_n;
        end
    end
endmodule
